// File: rtl/i2s_pkg.sv
// Shared types and defaults for the I2S transmit path.
package i2s_pkg;

    localparam int I2S_AUDIO_DW = 16;

    typedef struct packed {
        logic [I2S_AUDIO_DW-1:0] left;
        logic [I2S_AUDIO_DW-1:0] right;
    } i2s_frame_t;

endpackage

// File: rtl/i2s_sfifo_ram.sv
// Frame storage for the TX FIFO: one synchronous write port, combinational read.
module i2s_sfifo_ram #(
    parameter int DW     = 32,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DW-1:0]     wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DW-1:0]     rd_data
);

    logic [DW-1:0] mem [DEPTH];

    // No reset: stale contents are unreachable once the pointers are cleared.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/i2s_tx_frame_fifo.sv
// Stereo frame FIFO feeding i2s_tx; pops one frame on each LRCLK rising edge.
module i2s_tx_frame_fifo
    import i2s_pkg::*;
#(
    parameter int AUDIO_DW         = I2S_AUDIO_DW,
    parameter int DEPTH            = 8,
    parameter bit MUTE_ON_UNDERRUN = 1'b0,
    localparam int ADDR_W          = $clog2(DEPTH)
) (
    input  logic                i_tx_sclk,
    input  logic                i_tx_rst,
    input  logic                i_s_valid,
    output logic                o_s_ready,
    input  logic [AUDIO_DW-1:0] i_s_left,
    input  logic [AUDIO_DW-1:0] i_s_right,
    input  logic                i_tx_lrclk,
    output logic [AUDIO_DW-1:0] o_tx_left_chan,
    output logic [AUDIO_DW-1:0] o_tx_right_chan,
    output logic [ADDR_W:0]     o_level,
    output logic                o_empty,
    output logic                o_full,
    input  logic                i_clr_underrun,
    output logic                o_underrun
);

    localparam logic [ADDR_W:0]   LEVEL_MAX = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   LEVEL_ONE = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE   = ADDR_W'(1);

    logic [ADDR_W-1:0]     wr_ptr;
    logic [ADDR_W-1:0]     rd_ptr;
    logic                  lrclk_q;
    logic                  push;
    logic                  pop_req;
    logic                  pop;
    logic [2*AUDIO_DW-1:0] rd_data;

    // Handshake: a frame transfers on a clock edge where i_s_valid && o_s_ready;
    // the producer holds data stable while valid is high and ready is low.
    assign o_empty   = (o_level == '0);
    assign o_full    = (o_level == LEVEL_MAX);
    assign o_s_ready = ~o_full;

    assign push    = i_s_valid & o_s_ready;
    assign pop_req = i_tx_lrclk & ~lrclk_q;
    assign pop     = pop_req & ~o_empty;

    i2s_sfifo_ram #(
        .DW     (2*AUDIO_DW),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (i_tx_sclk),
        .we      (push),
        .wr_addr (wr_ptr),
        .wr_data ({i_s_left, i_s_right}),
        .rd_addr (rd_ptr),
        .rd_data (rd_data)
    );

    // lrclk_q resets high so an LRCLK already high at reset release is not a rise.
    always_ff @(posedge i_tx_sclk or posedge i_tx_rst) begin
        if (i_tx_rst) begin
            lrclk_q <= 1'b1;
        end else begin
            lrclk_q <= i_tx_lrclk;
        end
    end

    always_ff @(posedge i_tx_sclk or posedge i_tx_rst) begin
        if (i_tx_rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            o_level <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   o_level <= o_level + LEVEL_ONE;
                2'b01:   o_level <= o_level - LEVEL_ONE;
                default: o_level <= o_level;
            endcase
        end
    end

    // Output words only move on an LRCLK rise, so i2s_tx sees them stable all period.
    always_ff @(posedge i_tx_sclk or posedge i_tx_rst) begin
        if (i_tx_rst) begin
            o_tx_left_chan  <= '0;
            o_tx_right_chan <= '0;
        end else if (pop) begin
            o_tx_left_chan  <= rd_data[2*AUDIO_DW-1:AUDIO_DW];
            o_tx_right_chan <= rd_data[AUDIO_DW-1:0];
        end else if (pop_req && MUTE_ON_UNDERRUN) begin
            o_tx_left_chan  <= '0;
            o_tx_right_chan <= '0;
        end
    end

    // A fresh underrun wins over a simultaneous clear.
    always_ff @(posedge i_tx_sclk or posedge i_tx_rst) begin
        if (i_tx_rst) begin
            o_underrun <= 1'b0;
        end else if (pop_req && o_empty) begin
            o_underrun <= 1'b1;
        end else if (i_clr_underrun) begin
            o_underrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_i2s_tx_frame_fifo.sv
// Directed bench for i2s_tx_frame_fifo: pop expectations go to a queue checked by a monitor.
module tb_i2s_tx_frame_fifo;
    import i2s_pkg::*;

    localparam int DW    = 16;
    localparam int DEPTH = 8;
    localparam int AW    = $clog2(DEPTH);

    logic          clk;
    logic          rst;
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] s_left;
    logic [DW-1:0] s_right;
    logic          lrclk;
    logic [DW-1:0] tx_left;
    logic [DW-1:0] tx_right;
    logic [AW:0]   level;
    logic          empty;
    logic          full;
    logic          clr_underrun;
    logic          underrun;

    int n_cmp = 0;
    int n_err = 0;

    // Expected pop result: {underrun, left, right}
    logic [2*DW:0] exp_q[$];
    logic          lr_prev;

    i2s_tx_frame_fifo #(
        .AUDIO_DW         (DW),
        .DEPTH            (DEPTH),
        .MUTE_ON_UNDERRUN (1'b0)
    ) dut (
        .i_tx_sclk       (clk),
        .i_tx_rst        (rst),
        .i_s_valid       (s_valid),
        .o_s_ready       (s_ready),
        .i_s_left        (s_left),
        .i_s_right       (s_right),
        .i_tx_lrclk      (lrclk),
        .o_tx_left_chan  (tx_left),
        .o_tx_right_chan (tx_right),
        .o_level         (level),
        .o_empty         (empty),
        .o_full          (full),
        .i_clr_underrun  (clr_underrun),
        .o_underrun      (underrun)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_frame(input logic [DW-1:0] l, input logic [DW-1:0] r);
        chk("push_ready", 32'(s_ready), 32'd1);
        s_valid = 1'b1;
        s_left  = l;
        s_right = r;
        tick();
        s_valid = 1'b0;
    endtask

    task automatic lr_rise(input logic [DW-1:0] l, input logic [DW-1:0] r, input logic ur);
        exp_q.push_back({ur, l, r});
        lrclk = 1'b1;
        tick();
        tick();
        lrclk = 1'b0;
        tick();
    endtask

    // Monitor: on the edge where LRCLK is first sampled high, compare the popped frame.
    initial begin
        logic          rise;
        logic [2*DW:0] e;
        lr_prev = 1'b1;
        forever begin
            @(posedge clk);
            rise    = !rst && lrclk && !lr_prev;
            lr_prev = rst ? 1'b1 : lrclk;
            if (rise) begin
                @(negedge clk);
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_pop actual=%h/%h required=none", tx_left, tx_right);
                end else begin
                    e = exp_q.pop_front();
                    chk("pop_left", 32'(tx_left), 32'(e[2*DW-1:DW]));
                    chk("pop_right", 32'(tx_right), 32'(e[DW-1:0]));
                    chk("pop_underrun", 32'(underrun), 32'(e[2*DW]));
                end
            end
        end
    end

    // Watchdog
    initial begin
        #500000;
        n_err++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1, "watchdog");
    end

    initial begin
        rst          = 1'b1;
        lrclk        = 1'b1;
        s_valid      = 1'b0;
        s_left       = '0;
        s_right      = '0;
        clr_underrun = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        repeat (3) tick();

        // Reset released with LRCLK high: no pop, no underrun
        chk("rst_left", 32'(tx_left), 32'h0);
        chk("rst_right", 32'(tx_right), 32'h0);
        chk("rst_underrun", 32'(underrun), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_ready", 32'(s_ready), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        lrclk = 1'b0;
        tick();

        // Two frames in, two pops out in order
        push_frame(16'h1111, 16'h2222);
        push_frame(16'h3333, 16'h4444);
        chk("two_level", 32'(level), 32'd2);
        lr_rise(16'h1111, 16'h2222, 1'b0);
        chk("hold_left", 32'(tx_left), 32'h1111);
        lr_rise(16'h3333, 16'h4444, 1'b0);
        chk("two_empty", 32'(empty), 32'd1);

        // Fill to DEPTH, 9th frame refused
        for (int i = 0; i < DEPTH; i++) begin
            push_frame(16'hA000 + 16'(i), 16'hB000 + 16'(i));
        end
        chk("fill_full", 32'(full), 32'd1);
        chk("fill_ready", 32'(s_ready), 32'd0);
        chk("fill_level", 32'(level), 32'd8);
        s_valid = 1'b1;
        s_left  = 16'hDEAD;
        s_right = 16'hBEEF;
        tick();
        s_valid = 1'b0;
        chk("ninth_level", 32'(level), 32'd8);
        lr_rise(16'hA000, 16'hB000, 1'b0);
        chk("after_pop_ready", 32'(s_ready), 32'd1);
        chk("after_pop_level", 32'(level), 32'd7);

        // Full FIFO, valid held across a pop: pop first, push the next cycle
        push_frame(16'hC000, 16'hC001);
        chk("refill_level", 32'(level), 32'd8);
        exp_q.push_back({1'b0, 16'hA001, 16'hB001});
        s_valid = 1'b1;
        s_left  = 16'hD0D0;
        s_right = 16'hE0E0;
        lrclk   = 1'b1;
        tick();
        chk("full_pop_level", 32'(level), 32'd7);
        chk("full_pop_ready", 32'(s_ready), 32'd1);
        tick();
        s_valid = 1'b0;
        chk("full_push_level", 32'(level), 32'd8);
        lrclk = 1'b0;
        tick();

        for (int i = 2; i < 6; i++) begin
            lr_rise(16'hA000 + 16'(i), 16'hB000 + 16'(i), 1'b0);
        end
        chk("half_level", 32'(level), 32'd4);

        // Half full: simultaneous push and pop keeps the level
        exp_q.push_back({1'b0, 16'hA006, 16'hB006});
        s_valid = 1'b1;
        s_left  = 16'hF1F1;
        s_right = 16'hF2F2;
        lrclk   = 1'b1;
        tick();
        s_valid = 1'b0;
        chk("simul_level", 32'(level), 32'd4);
        tick();
        lrclk = 1'b0;
        tick();
        lr_rise(16'hA007, 16'hB007, 1'b0);
        lr_rise(16'hC000, 16'hC001, 1'b0);
        lr_rise(16'hD0D0, 16'hE0E0, 1'b0);
        lr_rise(16'hF1F1, 16'hF2F2, 1'b0);
        chk("drain_empty", 32'(empty), 32'd1);

        // Underrun holds the last frame; clear on a non-pop cycle
        lr_rise(16'hF1F1, 16'hF2F2, 1'b1);
        chk("ur_sticky", 32'(underrun), 32'd1);
        clr_underrun = 1'b1;
        tick();
        clr_underrun = 1'b0;
        chk("ur_clear", 32'(underrun), 32'd0);

        // Push into empty FIFO on an underrun pop: no bypass
        exp_q.push_back({1'b1, 16'hF1F1, 16'hF2F2});
        s_valid = 1'b1;
        s_left  = 16'h5555;
        s_right = 16'h6666;
        lrclk   = 1'b1;
        tick();
        s_valid = 1'b0;
        chk("nobypass_level", 32'(level), 32'd1);
        tick();
        lrclk = 1'b0;
        tick();
        clr_underrun = 1'b1;
        tick();
        clr_underrun = 1'b0;
        lr_rise(16'h5555, 16'h6666, 1'b0);

        // Async reset with 5 frames stored mid-frame
        for (int i = 0; i < 5; i++) begin
            push_frame(16'h7000 + 16'(i), 16'h8000 + 16'(i));
        end
        chk("pre_rst_level", 32'(level), 32'd5);
        rst = 1'b1;
        #2;
        chk("arst_left", 32'(tx_left), 32'h0);
        chk("arst_right", 32'(tx_right), 32'h0);
        chk("arst_level", 32'(level), 32'd0);
        chk("arst_empty", 32'(empty), 32'd1);
        chk("arst_ready", 32'(s_ready), 32'd1);
        tick();
        tick();
        rst = 1'b0;
        tick();
        lr_rise(16'h0000, 16'h0000, 1'b1);

        repeat (3) tick();
        chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
